// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// State encodings and a width helper for FIFO control blocks.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request scanning upward from last+1.
// Purely combinational; shared by write- and read-side schedulers.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         valid,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;
    logic         found;

    always_comb begin
        valid = |req;
        idx   = '0;
        found = 1'b0;
        cand  = last;
        // Explicit wrap compare keeps non-power-of-two N legal.
        for (int i = 0; i < N; i++) begin
            cand = (cand == W'(N - 1)) ? '0 : cand + 1'b1;
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among producers.
// Bursts of up to BURST_LEN words per grant, stalls on fifo_full.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    output logic                          fifo_we,
    output logic [DATA_WIDTH-1:0]         fifo_d,
    output logic [clog2(NUM_REQ)-1:0]     owner,
    output logic                          busy
);

    localparam int OW = clog2(NUM_REQ);
    localparam int CW = clog2(BURST_LEN + 1);

    arb_state_e      state_q;
    logic [OW-1:0]   owner_q;
    logic [OW-1:0]   last_q;
    logic [CW-1:0]   cnt_q;

    logic            pick_valid;
    logic [OW-1:0]   pick_idx;
    logic            accept;
    logic            last_word;

    logic [DATA_WIDTH-1:0] words [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = din[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    rr_pick #(
        .N (NUM_REQ),
        .W (OW)
    ) u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign accept    = (state_q == ST_XFER) & req[owner_q] & ~fifo_full;
    assign last_word = (cnt_q == CW'(BURST_LEN - 1));

    always_comb begin
        ack     = '0;
        fifo_we = 1'b0;
        fifo_d  = '0;
        if (accept) begin
            ack[owner_q] = 1'b1;
            fifo_we      = 1'b1;
            fifo_d       = words[owner_q];
        end
    end

    assign owner = owner_q;
    assign busy  = (state_q == ST_XFER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARB;
            owner_q <= '0;
            last_q  <= OW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_ARB: begin
                    if (pick_valid) begin
                        owner_q <= pick_idx;
                        cnt_q   <= '0;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (accept) cnt_q <= cnt_q + 1'b1;
                    // Dropped request or final burst word ends the grant.
                    if (!req[owner_q] || (accept && last_word)) begin
                        state_q <= ST_ARB;
                        last_q  <= owner_q;
                    end
                end
            endcase
        end
    end

endmodule
